// File: rtl/cam_bank_write_ctrl_if.sv
// ---------------------------------------------------------------------------
// cam_bank_write_ctrl_if
// Bundles the camera pins, host control, RAM write port and status of the
// camera frame-buffer write controller.
//
// Signals (direction as seen by the controller, modport slave):
//   VSYNCI, HREFI, DATAI  in   camera frame/line qualifiers and pixel byte
//   arm_i                 in   host capture enable (WB domain level)
//   bank_rel_tgl_i        in   host bank release toggles (WB domain)
//   ram_wa_o / ram_wd_o   out  RAM word address / packed write data
//   ram_wen_o             out  one-hot per-bank write strobe
//   bank_full_o           out  per-bank "holds unread data" flags
//   cur_bank_o            out  bank currently being filled
//   last_wcnt_o           out  word count of the last closed bank
//   frame_done_o          out  end-of-completed-frame pulse
//   overflow_o            out  sticky dropped-bytes flag
//   state_o               out  controller FSM state
//
// Transfer semantics: there is no back-pressure on either side. A pixel byte
// is transferred on every PCLKI rising edge where HREFI & VSYNCI is high; a
// RAM word is transferred on every PCLKI rising edge where one bit of
// ram_wen_o is high, with ram_wa_o/ram_wd_o valid in that same cycle.
// ---------------------------------------------------------------------------
interface cam_bank_write_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              VSYNCI;
  logic              HREFI;
  logic [7:0]        DATAI;
  logic              arm_i;
  logic [3:0]        bank_rel_tgl_i;
  logic [ADDR_W-1:0] ram_wa_o;
  logic [31:0]       ram_wd_o;
  logic [3:0]        ram_wen_o;
  logic [3:0]        bank_full_o;
  logic [1:0]        cur_bank_o;
  logic [ADDR_W:0]   last_wcnt_o;
  logic              frame_done_o;
  logic              overflow_o;
  logic [1:0]        state_o;

  modport master (
    output VSYNCI, HREFI, DATAI, arm_i, bank_rel_tgl_i,
    input  ram_wa_o, ram_wd_o, ram_wen_o, bank_full_o, cur_bank_o,
    input  last_wcnt_o, frame_done_o, overflow_o, state_o
  );

  modport slave (
    input  VSYNCI, HREFI, DATAI, arm_i, bank_rel_tgl_i,
    output ram_wa_o, ram_wd_o, ram_wen_o, bank_full_o, cur_bank_o,
    output last_wcnt_o, frame_done_o, overflow_o, state_o
  );
endinterface

// File: rtl/cam_bank_write_ctrl.sv
// ---------------------------------------------------------------------------
// cam_bank_write_ctrl
// Write-side controller of the camera frame buffer (4 banks of
// WORDS_PER_BANK x 32). Packs pixel bytes little-endian into 32-bit words,
// writes them round-robin across the banks, keeps per-bank full flags that
// the host releases from the Wishbone domain, and gates capture per frame
// with the host arm level.
//
// Ports:
//   PCLKI      in  camera pixel clock, all logic on its rising edge
//   WBs_RST_i  in  asynchronous active-high reset
//   bus        cam_bank_write_ctrl_if.slave (camera pins, host control,
//              RAM write port, status and FSM state)
// ---------------------------------------------------------------------------
module cam_bank_write_ctrl #(
  parameter int WORDS_PER_BANK = 512,
  parameter int ADDR_W         = 9
) (
  input  logic                  PCLKI,
  input  logic                  WBs_RST_i,
  cam_bank_write_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    CAPTURE    = 2'd2,
    STALL      = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_BANK - 1);
  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(WORDS_PER_BANK);

  state_t            state_q;
  logic              arm_s1_q, arm_s2_q;
  logic [3:0]        rel_s1_q, rel_s2_q, rel_s3_q;
  logic              vs_q;
  logic [1:0]        byte_cnt_q;
  logic [23:0]       pack_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        cur_bank_q;
  logic [3:0]        bank_full_q;
  logic [ADDR_W:0]   last_wcnt_q;
  logic [ADDR_W-1:0] wa_q;
  logic [31:0]       wd_q;
  logic [3:0]        wen_q;
  logic              frame_done_q;
  logic              overflow_q;

  logic       byte_vld;
  logic       vs_rise;
  logic       vs_fall;
  logic [3:0] rel_pulse;
  logic [3:0] cur_onehot;

  assign byte_vld   = bus.HREFI & bus.VSYNCI;
  assign vs_rise    = bus.VSYNCI & ~vs_q;
  assign vs_fall    = ~bus.VSYNCI & vs_q;
  // Any change of a synchronised toggle bit is one release of that bank.
  assign rel_pulse  = rel_s2_q ^ rel_s3_q;
  assign cur_onehot = 4'b0001 << cur_bank_q;

  always_ff @(posedge PCLKI or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state_q      <= IDLE;
      arm_s1_q     <= 1'b0;
      arm_s2_q     <= 1'b0;
      rel_s1_q     <= 4'b0;
      rel_s2_q     <= 4'b0;
      rel_s3_q     <= 4'b0;
      vs_q         <= 1'b0;
      byte_cnt_q   <= 2'd0;
      pack_q       <= 24'd0;
      addr_q       <= '0;
      cur_bank_q   <= 2'd0;
      bank_full_q  <= 4'b0;
      last_wcnt_q  <= '0;
      wa_q         <= '0;
      wd_q         <= 32'd0;
      wen_q        <= 4'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      arm_s1_q     <= bus.arm_i;
      arm_s2_q     <= arm_s1_q;
      rel_s1_q     <= bus.bank_rel_tgl_i;
      rel_s2_q     <= rel_s1_q;
      rel_s3_q     <= rel_s2_q;
      vs_q         <= bus.VSYNCI;
      wen_q        <= 4'b0;
      frame_done_q <= 1'b0;
      // Releases first; a close of the same bank later in this block
      // overrides the cleared bit, so a close always wins.
      bank_full_q  <= bank_full_q & ~rel_pulse;

      case (state_q)
        IDLE: begin
          byte_cnt_q <= 2'd0;
          if (arm_s2_q) state_q <= WAIT_FRAME;
        end

        WAIT_FRAME: begin
          byte_cnt_q <= 2'd0;
          // Only a fresh VSYNC rise starts capture, so a frame already
          // running when arm arrived is skipped.
          if (!arm_s2_q)    state_q <= IDLE;
          else if (vs_rise) state_q <= CAPTURE;
        end

        CAPTURE, STALL: begin
          if (vs_fall) begin
            // Frame end: partial word dropped, a partly filled bank closes.
            byte_cnt_q   <= 2'd0;
            frame_done_q <= 1'b1;
            if (addr_q != '0) begin
              bank_full_q[cur_bank_q] <= 1'b1;
              last_wcnt_q             <= {1'b0, addr_q};
              cur_bank_q              <= cur_bank_q + 2'd1;
              addr_q                  <= '0;
            end
            state_q <= arm_s2_q ? WAIT_FRAME : IDLE;
          end else if (!arm_s2_q) begin
            // Abort: the open bank keeps its address for the next frame.
            byte_cnt_q <= 2'd0;
            state_q    <= IDLE;
          end else if (state_q == STALL) begin
            if (byte_vld) overflow_q <= 1'b1;
            if (!bank_full_q[cur_bank_q]) begin
              state_q    <= CAPTURE;
              byte_cnt_q <= 2'd0;
              addr_q     <= '0;
            end
          end else if (byte_vld) begin
            if (byte_cnt_q == 2'd3) begin
              byte_cnt_q <= 2'd0;
              if (bank_full_q[cur_bank_q]) begin
                // Target bank still unread: this word is lost.
                state_q    <= STALL;
                overflow_q <= 1'b1;
              end else begin
                wd_q  <= {bus.DATAI, pack_q};
                wa_q  <= addr_q;
                wen_q <= cur_onehot;
                if (addr_q == LAST_ADDR) begin
                  bank_full_q[cur_bank_q] <= 1'b1;
                  last_wcnt_q             <= FULL_CNT;
                  cur_bank_q              <= cur_bank_q + 2'd1;
                  addr_q                  <= '0;
                end else begin
                  addr_q <= addr_q + 1'b1;
                end
              end
            end else begin
              case (byte_cnt_q)
                2'd0:    pack_q[7:0]   <= bus.DATAI;
                2'd1:    pack_q[15:8]  <= bus.DATAI;
                default: pack_q[23:16] <= bus.DATAI;
              endcase
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ram_wa_o     = wa_q;
  assign bus.ram_wd_o     = wd_q;
  assign bus.ram_wen_o    = wen_q;
  assign bus.bank_full_o  = bank_full_q;
  assign bus.cur_bank_o   = cur_bank_q;
  assign bus.last_wcnt_o  = last_wcnt_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.overflow_o   = overflow_q;
  assign bus.state_o      = state_q;

endmodule

// File: tb/tb_cam_bank_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cam_bank_write_ctrl
// Bench for cam_bank_write_ctrl: every RAM write is matched against an
// expected queue of {bank, address, word}; frame-level results come from a
// table of short frames plus hand-written long-frame, stall, arm and reset
// sequences.
// ---------------------------------------------------------------------------
module tb_cam_bank_write_ctrl;
  localparam int W = 43;  // {bank[1:0], addr[8:0], word[31:0]}

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cam_bank_write_ctrl_if bus ();

  cam_bank_write_ctrl dut (
    .PCLKI     (clk),
    .WBs_RST_i (rst),
    .bus       (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  int           fd_cnt;
  int           wr_cnt[4];

  // Reference model of where the next packed word lands.
  logic [1:0]  m_bank;
  logic [8:0]  m_addr;
  logic [31:0] m_word;
  int          m_nb;

  typedef struct {
    int         nbytes;
    logic [9:0] exp_last;
    logic [1:0] exp_cur;
    logic [3:0] exp_full;
    logic [3:0] rel_after;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- write scoreboard ----------------
  logic [1:0]   mon_bank;
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_done_o) fd_cnt++;
      if (bus.ram_wen_o != 4'b0000) begin
        chk("wen_onehot", $countones(bus.ram_wen_o), 1);
        case (bus.ram_wen_o)
          4'b0010: mon_bank = 2'd1;
          4'b0100: mon_bank = 2'd2;
          4'b1000: mon_bank = 2'd3;
          default: mon_bank = 2'd0;
        endcase
        mon_got = {mon_bank, bus.ram_wa_o, bus.ram_wd_o};
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%h expected=none", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("write", mon_got, mon_exp);
        end
        wr_cnt[mon_bank]++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_advance();
    if (m_addr == 9'd511) begin
      m_addr = 9'd0;
      m_bank = m_bank + 2'd1;
    end else begin
      m_addr = m_addr + 9'd1;
    end
  endtask

  // One valid byte; HREFI stays high so bytes stream back to back.
  task automatic send_byte(input logic [7:0] d, input bit push);
    bus.HREFI = 1'b1;
    bus.DATAI = d;
    m_word    = {d, m_word[31:8]};
    m_nb++;
    if (m_nb == 4) begin
      m_nb = 0;
      if (push) begin
        exp_q.push_back({m_bank, m_addr, m_word});
        model_advance();
      end
    end
    tick();
  endtask

  task automatic send_rand(input int n, input bit push);
    for (int i = 0; i < n; i++) send_byte(8'($urandom_range(0, 255)), push);
  endtask

  task automatic frame_begin();
    m_nb       = 0;
    bus.HREFI  = 1'b0;
    bus.VSYNCI = 1'b1;
    tick(2);
  endtask

  task automatic frame_end(input bit model_close);
    bus.HREFI = 1'b0;
    tick();
    bus.VSYNCI = 1'b0;
    tick(3);
    m_nb = 0;
    if (model_close && m_addr != 9'd0) begin
      m_addr = 9'd0;
      m_bank = m_bank + 2'd1;
    end
  endtask

  task automatic release_banks(input logic [3:0] mask);
    bus.bank_rel_tgl_i = bus.bank_rel_tgl_i ^ mask;
  endtask

  // ---------------- test sequence ----------------
  int fd0;
  int wr0[4];

  initial begin
    vecs[0] = '{6,  10'd1, 2'd2, 4'b0010, 4'b0000};  // one word, bytes 5-6 dropped
    vecs[1] = '{3,  10'd1, 2'd2, 4'b0010, 4'b0000};  // no word, no close
    vecs[2] = '{4,  10'd1, 2'd3, 4'b0110, 4'b0000};
    vecs[3] = '{13, 10'd3, 2'd0, 4'b1110, 4'b0000};
    vecs[4] = '{8,  10'd2, 2'd1, 4'b1111, 4'b1111};

    bus.VSYNCI = 1'b0;
    bus.HREFI = 1'b0;
    bus.DATAI = 8'h00;
    bus.arm_i = 1'b0;
    bus.bank_rel_tgl_i = 4'b0;
    m_bank = 2'd0; m_addr = 9'd0; m_word = 32'd0; m_nb = 0;
    rst = 1'b1;
    tick(3);

    // Reset state
    chk("rst_state", bus.state_o, 2'd0);
    chk("rst_wen", bus.ram_wen_o, 4'b0);
    chk("rst_wa", bus.ram_wa_o, 9'd0);
    chk("rst_wd", bus.ram_wd_o, 32'd0);
    chk("rst_full", bus.bank_full_o, 4'b0);
    chk("rst_cur", bus.cur_bank_o, 2'd0);
    chk("rst_last", bus.last_wcnt_o, 10'd0);
    chk("rst_fd", bus.frame_done_o, 1'b0);
    chk("rst_ovf", bus.overflow_o, 1'b0);
    rst = 1'b0;
    tick(2);
    chk("idle_unarmed", bus.state_o, 2'd0);

    // T1: 8 known bytes into bank0
    bus.arm_i = 1'b1;
    tick(4);
    chk("t1_wait_frame", bus.state_o, 2'd1);
    exp_q.push_back({2'd0, 9'd0, 32'h04030201});
    exp_q.push_back({2'd0, 9'd1, 32'h08070605});
    fd0 = fd_cnt;
    frame_begin();
    chk("t1_capture", bus.state_o, 2'd2);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
    frame_end(1'b0);
    m_bank = 2'd1; m_addr = 9'd0;
    chk("t1_fd", fd_cnt - fd0, 1);
    chk("t1_last", bus.last_wcnt_o, 10'd2);
    chk("t1_full", bus.bank_full_o, 4'b0001);
    chk("t1_cur", bus.cur_bank_o, 2'd1);
    chk("t1_state", bus.state_o, 2'd1);
    chk("t1_q_empty", exp_q.size(), 0);

    // Release latency: flag still set after 2 edges, clear after 3
    release_banks(4'b0001);
    tick(2);
    chk("rel_2cyc", bus.bank_full_o, 4'b0001);
    tick();
    chk("rel_3cyc", bus.bank_full_o, 4'b0000);

    // Table of short frames
    for (int v = 0; v < 5; v++) begin
      fd0 = fd_cnt;
      frame_begin();
      send_rand(vecs[v].nbytes, 1'b1);
      frame_end(1'b1);
      chk("vec_fd", fd_cnt - fd0, 1);
      chk("vec_last", bus.last_wcnt_o, vecs[v].exp_last);
      chk("vec_cur", bus.cur_bank_o, vecs[v].exp_cur);
      chk("vec_full", bus.bank_full_o, vecs[v].exp_full);
      chk("vec_state", bus.state_o, 2'd1);
      chk("vec_ovf", bus.overflow_o, 1'b0);
      chk("vec_q_empty", exp_q.size(), 0);
      if (vecs[v].rel_after != 4'b0) begin
        release_banks(vecs[v].rel_after);
        tick(4);
        chk("vec_rel", bus.bank_full_o, 4'b0000);
      end
    end

    // T6: reset one byte into a word
    frame_begin();
    send_rand(9, 1'b1);
    chk("t6_pre_state", bus.state_o, 2'd2);
    rst = 1'b1;
    bus.HREFI = 1'b0;
    bus.VSYNCI = 1'b0;
    #1;
    chk("t6_state", bus.state_o, 2'd0);
    chk("t6_wa", bus.ram_wa_o, 9'd0);
    chk("t6_wd", bus.ram_wd_o, 32'd0);
    chk("t6_cur", bus.cur_bank_o, 2'd0);
    chk("t6_last", bus.last_wcnt_o, 10'd0);
    chk("t6_full", bus.bank_full_o, 4'b0);
    chk("t6_q_empty", exp_q.size(), 0);
    tick(2);
    rst = 1'b0;
    m_bank = 2'd0; m_addr = 9'd0; m_nb = 0;
    tick(4);
    chk("t6_rearm", bus.state_o, 2'd1);

    // T2: four full banks plus one word, each bank released once full
    for (int b = 0; b < 4; b++) wr0[b] = wr_cnt[b];
    fd0 = fd_cnt;
    frame_begin();
    for (int i = 0; i < 8196; i++) begin
      send_byte(8'($urandom_range(0, 255)), 1'b1);
      if ((i + 1) % 2048 == 0) release_banks(4'b0001 << ((i + 1) / 2048 - 1));
    end
    chk("t2_cur_wrap", bus.cur_bank_o, 2'd0);
    chk("t2_last_full", bus.last_wcnt_o, 10'd512);
    chk("t2_state", bus.state_o, 2'd2);
    frame_end(1'b1);
    chk("t2_ovf", bus.overflow_o, 1'b0);
    chk("t2_full", bus.bank_full_o, 4'b0001);
    chk("t2_last", bus.last_wcnt_o, 10'd1);
    chk("t2_cur", bus.cur_bank_o, 2'd1);
    chk("t2_fd", fd_cnt - fd0, 1);
    chk("t2_wr0", wr_cnt[0] - wr0[0], 513);
    chk("t2_wr1", wr_cnt[1] - wr0[1], 512);
    chk("t2_wr2", wr_cnt[2] - wr0[2], 512);
    chk("t2_wr3", wr_cnt[3] - wr0[3], 512);
    chk("t2_q_empty", exp_q.size(), 0);
    release_banks(4'b0001);
    tick(4);

    // T3: fill all banks without releases, then stall and recover
    fd0 = fd_cnt;
    frame_begin();
    send_rand(8192, 1'b1);
    send_rand(8, 1'b0);
    bus.HREFI = 1'b0;
    chk("t3_stall", bus.state_o, 2'd3);
    chk("t3_ovf", bus.overflow_o, 1'b1);
    chk("t3_full", bus.bank_full_o, 4'b1111);
    chk("t3_cur", bus.cur_bank_o, 2'd1);
    release_banks(4'b0010);
    tick(2);
    chk("t3_rel_2cyc", bus.bank_full_o, 4'b1111);
    tick();
    chk("t3_rel_3cyc", bus.bank_full_o, 4'b1101);
    tick();
    chk("t3_resume", bus.state_o, 2'd2);
    m_nb = 0;
    send_rand(4, 1'b1);
    frame_end(1'b1);
    chk("t3_fd", fd_cnt - fd0, 1);
    chk("t3_last", bus.last_wcnt_o, 10'd1);
    chk("t3_end_full", bus.bank_full_o, 4'b1111);
    chk("t3_ovf_sticky", bus.overflow_o, 1'b1);
    chk("t3_q_empty", exp_q.size(), 0);

    // T5: arm mid-frame skips that frame; disarm mid-frame aborts
    release_banks(4'b1111);
    tick(4);
    chk("t5_full_clr", bus.bank_full_o, 4'b0000);
    bus.arm_i = 1'b0;
    tick(3);
    chk("t5_idle", bus.state_o, 2'd0);
    for (int b = 0; b < 4; b++) wr0[b] = wr_cnt[b];
    fd0 = fd_cnt;
    frame_begin();
    send_rand(4, 1'b0);
    bus.arm_i = 1'b1;
    send_rand(8, 1'b0);
    chk("t5_skip_state", bus.state_o, 2'd1);
    frame_end(1'b0);
    chk("t5_skip_writes", (wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3]) -
        (wr0[0] + wr0[1] + wr0[2] + wr0[3]), 0);
    chk("t5_skip_fd", fd_cnt - fd0, 0);
    frame_begin();
    send_rand(8, 1'b1);
    bus.HREFI = 1'b0;
    bus.arm_i = 1'b0;
    tick(4);
    chk("t5_abort_state", bus.state_o, 2'd0);
    chk("t5_abort_full", bus.bank_full_o, 4'b0000);
    chk("t5_abort_cur", bus.cur_bank_o, 2'd2);
    bus.VSYNCI = 1'b0;
    tick(3);
    chk("t5_abort_fd", fd_cnt - fd0, 0);
    chk("t5_q_empty", exp_q.size(), 0);

    tick(2);
    chk("final_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
